pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle datapath. It supersedes the fixed +4 adder.
- Holds the PC register and produces PC+INC combinationally.
- Selects the next PC from three sources: sequential, branch target or jump target.
- Supports stall (hold), a one-cycle boot state after reset, a misaligned-target trap with an exception PC register, and a retired-instruction counter.

Parameters:
- WIDTH, 32: PC/address width in bits.
- INC, 4: byte increment per instruction. Must be a power of two, at least 1.
- RESET_VEC, 0: PC value loaded on reset. Must be INC-aligned.
- TRAP_VEC, 'h80: PC loaded on a misaligned redirect. Must be INC-aligned.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- stall, input, 1: hold PC and counter this cycle.
- branch_taken, input, 1: redirect to branch_target.
- branch_target, input, WIDTH: branch destination.
- jump, input, 1: redirect to jump_target.
- jump_target, input, WIDTH: jump destination.
- pc, output, WIDTH: current PC (registered).
- pc_plus_inc, output, WIDTH: pc + INC, combinational, modulo 2^WIDTH.
- pc_valid, output, 1: pc addresses an instruction to execute this cycle.
- misalign, output, 1: one-cycle pulse, a misaligned redirect was taken.
- epc, output, WIDTH: PC of the instruction whose redirect faulted.
- instr_count, output, CNT_W: number of instructions retired.

Behaviour:
- Reset (asynchronous, takes effect immediately) sets: pc=RESET_VEC, state=BOOT, pc_valid=0, misalign=0, epc=0, instr_count=0.
- States: BOOT, RUN, TRAP. Encoded in 2 bits.
- pc_valid=1 only in RUN. It is registered, i.e. derived from the state register.
- BOOT:
  - pc stays RESET_VEC.
  - stall=1: remain in BOOT.
  - Otherwise: go to RUN next cycle. The first valid fetch is at RESET_VEC, one cycle after reset release.
  - Redirect inputs are ignored.
- RUN with stall=1: pc, epc, instr_count and state all hold. Redirect inputs are ignored; the driver must keep them asserted until the stall clears.
- RUN with stall=0:
  - Target priority: jump (jump_target) > branch_taken (branch_target) > sequential (pc_plus_inc).
  - If the target is a redirect and its low log2(INC) bits are non-zero:
    - pc <= TRAP_VEC, epc <= pc, misalign <= 1 for exactly one cycle, state <= TRAP.
  - Otherwise: pc <= target, state stays RUN.
  - instr_count <= instr_count + 1 in both cases. The faulting instruction counts as retired.
- TRAP:
  - One bubble cycle: pc_valid=0, pc stays TRAP_VEC.
  - Next state is RUN unless stall=1, in which case remain in TRAP.
  - Redirects are ignored.
  - misalign is 0 in TRAP after its single pulse.
- When INC=1, alignment checking is disabled and misalign never asserts.
- Arithmetic:
  - pc_plus_inc wraps modulo 2^WIDTH, e.g. 'hFFFF_FFFC + 4 = 0.
  - instr_count wraps modulo 2^CNT_W.
- A misaligned redirect is checked only when it is the selected source. Example: jump and branch are both asserted, jump_target is aligned and branch_target is misaligned → no trap.
- Reset asserted mid-operation aborts the cycle and forces the reset values above. Any in-flight trap is lost and epc is cleared.

Decomposition:
- Shared package pc_pkg holds:
  - state encoding constants: ST_BOOT=0, ST_RUN=1, ST_TRAP=2;
  - the next-PC source select constants: SEL_SEQ, SEL_BR, SEL_JMP.
- One sub-module, pc_incr: parametrised WIDTH/INC combinational adder producing pc_plus_inc. It is the generalised successor to the fixed incrementer.
- pc_unit contains the state machine, next-PC mux, alignment check and registers.

Test Plan:
- Reset and boot: assert rst, release, no stall → cycle 0: pc=0, pc_valid=0. Cycle 1: pc=0, pc_valid=1. Cycle 2: pc=4, instr_count=1.
- Priority: in RUN at pc='h10, assert jump=1 (target 'h100) and branch_taken=1 (target 'h200) → next pc='h100. Then branch only (target 'h40) → next pc='h40.
- Stall: at pc='h20, hold stall=1 for 3 cycles with branch_taken=1 → pc stays 'h20 and instr_count is unchanged. Release stall → next pc=branch_target.
- Misaligned redirect: at pc='h30, jump_target='h102 → next cycle: pc='h80, misalign=1, epc='h30, pc_valid=0. Following cycle: pc_valid=1, misalign=0, pc='h80. Next: pc='h84.
- Wrap: force pc='hFFFF_FFFC via jump → pc_plus_inc=0, next sequential pc=0.
- Async reset mid-run: assert rst between clock edges while in TRAP → pc=RESET_VEC, epc=0, instr_count=0 immediately, before the next edge.
- Parameter sweep: WIDTH=16, INC=2, RESET_VEC='h100 → first valid pc='h100, then 'h102. A jump to 'h105 traps; a jump to 'h106 does not.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: constants shared by the program-counter unit.
//   ST_*  : 2-bit state encodings for the BOOT/RUN/TRAP sequencer.
//   SEL_* : next-PC source select (sequential, branch, jump).
package pc_pkg;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;

    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_JMP = 2'd2;

endpackage

// File: rtl/pc_incr.sv
// pc_incr: combinational PC incrementer, generalised from the fixed +4 adder.
//   pc          : current program counter
//   pc_plus_inc : pc + INC, wrapping modulo 2^WIDTH
module pc_incr #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned INC   = 4
) (
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_inc
);

    always_comb begin
        pc_plus_inc = pc + WIDTH'(INC);
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter register with next-PC selection, a one-cycle boot
// state, misaligned-redirect trap with exception PC, and a retired counter.
//   clk, rst                   : clock, asynchronous active-high reset
//   stall                      : hold PC, counter and state this cycle
//   branch_taken/branch_target : branch redirect request and destination
//   jump/jump_target           : jump redirect (beats branch) and destination
//   pc, pc_plus_inc            : registered PC and its combinational successor
//   pc_valid                   : pc is an instruction to execute (RUN only)
//   misalign                   : one-cycle pulse after a misaligned redirect
//   epc                        : PC of the instruction whose redirect faulted
//   instr_count                : retired-instruction counter (wraps)
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter int unsigned       INC       = 4,
    parameter logic [WIDTH-1:0]  RESET_VEC = '0,
    parameter logic [WIDTH-1:0]  TRAP_VEC  = WIDTH'('h80),
    parameter int unsigned       CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             pc_valid,
    output logic             misalign,
    output logic [WIDTH-1:0] epc,
    output logic [CNT_W-1:0] instr_count
);

    // Low log2(INC) bits must be zero; INC=1 yields an all-zero mask, which
    // disables the alignment check without any special casing.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] pc_q,       pc_d;
    logic [WIDTH-1:0] epc_q,      epc_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             misalign_q, misalign_d;

    logic [1:0]       sel;
    logic [WIDTH-1:0] target;
    logic             target_misaligned;

    pc_incr #(
        .WIDTH (WIDTH),
        .INC   (INC)
    ) u_incr (
        .pc          (pc_q),
        .pc_plus_inc (pc_plus_inc)
    );

    always_comb begin
        if (jump) begin
            sel = SEL_JMP;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end else begin
            sel = SEL_SEQ;
        end
    end

    always_comb begin
        case (sel)
            SEL_JMP: target = jump_target;
            SEL_BR:  target = branch_target;
            default: target = pc_plus_inc;
        endcase
    end

    // Only the selected redirect is checked; the sequential successor of an
    // aligned PC is aligned by construction.
    always_comb begin
        target_misaligned = (sel != SEL_SEQ) && ((target & ALIGN_MASK) != '0);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;

        case (state_q)
            ST_BOOT: begin
                if (!stall) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (target_misaligned) begin
                        pc_d       = TRAP_VEC;
                        epc_d      = pc_q;
                        misalign_d = 1'b1;
                        state_d    = ST_TRAP;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            ST_TRAP: begin
                if (!stall) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // Unused encoding: restart cleanly through BOOT.
                state_d = ST_BOOT;
                pc_d    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        pc          = pc_q;
        pc_valid    = (state_q == ST_RUN);
        misalign    = misalign_q;
        epc         = epc_q;
        instr_count = cnt_q;
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed-vector bench for pc_unit. Stimulus pushes the
// hand-computed state expected after each clock edge into a scoreboard; a
// monitor pops and compares on the falling edge. Instance A uses default
// parameters, instance B uses WIDTH=16, INC=2, RESET_VEC='h100.
module tb_pc_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] jump_target = '0;

    logic [31:0] pc_a, ppi_a, epc_a, cnt_a;
    logic        valid_a, mis_a;
    logic [15:0] pc_b, ppi_b, epc_b;
    logic [31:0] cnt_b;
    logic        valid_b, mis_b;

    pc_unit u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc            (pc_a),
        .pc_plus_inc   (ppi_a),
        .pc_valid      (valid_a),
        .misalign      (mis_a),
        .epc           (epc_a),
        .instr_count   (cnt_a)
    );

    pc_unit #(
        .WIDTH     (16),
        .INC       (2),
        .RESET_VEC (16'h0100)
    ) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target[15:0]),
        .jump          (jump),
        .jump_target   (jump_target[15:0]),
        .pc            (pc_b),
        .pc_plus_inc   (ppi_b),
        .pc_valid      (valid_b),
        .misalign      (mis_b),
        .epc           (epc_b),
        .instr_count   (cnt_b)
    );

    typedef struct {
        int unsigned dut;
        int unsigned id;
        logic [31:0] pc;
        logic [31:0] ppi;
        logic [31:0] epc;
        logic [31:0] cnt;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned vec_id = 0;

    task automatic expect_state(input int unsigned dut, input logic [31:0] pc,
                                input logic valid, input logic mis,
                                input logic [31:0] epc, input logic [31:0] cnt);
        exp_t e;
        e.dut   = dut;
        e.id    = vec_id;
        e.pc    = pc;
        e.ppi   = (dut == 0) ? (pc + 32'd4) : ((pc + 32'd2) & 32'h0000_FFFF);
        e.epc   = epc;
        e.cnt   = cnt;
        e.valid = valid;
        e.mis   = mis;
        vec_id++;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every falling edge, compare all pending expectations.
    initial begin
        exp_t        e;
        logic [31:0] a_pc, a_ppi, a_epc, a_cnt;
        logic        a_valid, a_mis;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.dut == 0) begin
                    a_pc = pc_a; a_ppi = ppi_a; a_epc = epc_a; a_cnt = cnt_a;
                    a_valid = valid_a; a_mis = mis_a;
                end else begin
                    a_pc = {16'h0, pc_b}; a_ppi = {16'h0, ppi_b}; a_epc = {16'h0, epc_b};
                    a_cnt = cnt_b; a_valid = valid_b; a_mis = mis_b;
                end
                checks++;
                if (a_pc !== e.pc || a_ppi !== e.ppi || a_epc !== e.epc ||
                    a_cnt !== e.cnt || a_valid !== e.valid || a_mis !== e.mis) begin
                    failures++;
                    $display("FAIL vec%0d dut%0d: got pc=%h ppi=%h valid=%b mis=%b epc=%h cnt=%0d, want pc=%h ppi=%h valid=%b mis=%b epc=%h cnt=%0d",
                             e.id, e.dut, a_pc, a_ppi, a_valid, a_mis, a_epc, a_cnt,
                             e.pc, e.ppi, e.valid, e.mis, e.epc, e.cnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and boot
        cyc(); cyc();
        expect_state(0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        rst = 1'b0;
        cyc(); expect_state(0, 32'h0,  1'b1, 1'b0, 32'h0, 0);
        cyc(); expect_state(0, 32'h4,  1'b1, 1'b0, 32'h0, 1);
        cyc(); expect_state(0, 32'h8,  1'b1, 1'b0, 32'h0, 2);
        cyc(); expect_state(0, 32'hC,  1'b1, 1'b0, 32'h0, 3);
        cyc(); expect_state(0, 32'h10, 1'b1, 1'b0, 32'h0, 4);

        // Priority: jump beats branch, then branch alone
        jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200;
        cyc(); expect_state(0, 32'h100, 1'b1, 1'b0, 32'h0, 5);
        jump = 1'b0; branch_target = 32'h40;
        cyc(); expect_state(0, 32'h40, 1'b1, 1'b0, 32'h0, 6);

        // Stall with branch held
        branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h20;
        cyc(); expect_state(0, 32'h20, 1'b1, 1'b0, 32'h0, 7);
        jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h60; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); expect_state(0, 32'h20, 1'b1, 1'b0, 32'h0, 7);
        end
        stall = 1'b0;
        cyc(); expect_state(0, 32'h60, 1'b1, 1'b0, 32'h0, 8);

        // Misaligned jump traps; redirect during TRAP is ignored
        branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h30;
        cyc(); expect_state(0, 32'h30, 1'b1, 1'b0, 32'h0, 9);
        jump_target = 32'h102;
        cyc(); expect_state(0, 32'h80, 1'b0, 1'b1, 32'h30, 10);
        jump_target = 32'h200;
        cyc(); expect_state(0, 32'h80, 1'b1, 1'b0, 32'h30, 10);
        jump = 1'b0;
        cyc(); expect_state(0, 32'h84, 1'b1, 1'b0, 32'h30, 11);

        // Aligned jump wins over misaligned branch: no trap
        jump = 1'b1; jump_target = 32'h88; branch_taken = 1'b1; branch_target = 32'h93;
        cyc(); expect_state(0, 32'h88, 1'b1, 1'b0, 32'h30, 12);

        // Wrap of pc_plus_inc
        branch_taken = 1'b0; jump_target = 32'hFFFF_FFFC;
        cyc(); expect_state(0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h30, 13);
        jump = 1'b0;
        cyc(); expect_state(0, 32'h0, 1'b1, 1'b0, 32'h30, 14);
        cyc(); expect_state(0, 32'h4, 1'b1, 1'b0, 32'h30, 15);

        // Trap, hold in TRAP via stall, then asynchronous reset between edges
        jump = 1'b1; jump_target = 32'h7;
        cyc(); expect_state(0, 32'h80, 1'b0, 1'b1, 32'h4, 16);
        jump = 1'b0; stall = 1'b1;
        cyc();
        rst = 1'b1;
        expect_state(0, 32'h0,   1'b0, 1'b0, 32'h0, 0);
        expect_state(1, 32'h100, 1'b0, 1'b0, 32'h0, 0);
        cyc();
        expect_state(0, 32'h0,   1'b0, 1'b0, 32'h0, 0);
        expect_state(1, 32'h100, 1'b0, 1'b0, 32'h0, 0);
        rst = 1'b0; stall = 1'b0;

        // Both instances: boot, then parameter-dependent alignment
        cyc();
        expect_state(0, 32'h0,   1'b1, 1'b0, 32'h0, 0);
        expect_state(1, 32'h100, 1'b1, 1'b0, 32'h0, 0);
        cyc();
        expect_state(0, 32'h4,   1'b1, 1'b0, 32'h0, 1);
        expect_state(1, 32'h102, 1'b1, 1'b0, 32'h0, 1);
        jump = 1'b1; jump_target = 32'h105;
        cyc();
        expect_state(0, 32'h80, 1'b0, 1'b1, 32'h4,   2);
        expect_state(1, 32'h80, 1'b0, 1'b1, 32'h102, 2);
        jump = 1'b0;
        cyc();
        expect_state(0, 32'h80, 1'b1, 1'b0, 32'h4,   2);
        expect_state(1, 32'h80, 1'b1, 1'b0, 32'h102, 2);
        jump = 1'b1; jump_target = 32'h106;
        cyc();
        expect_state(0, 32'h80,  1'b0, 1'b1, 32'h80,  3);
        expect_state(1, 32'h106, 1'b1, 1'b0, 32'h102, 3);
        jump = 1'b0;
        cyc();
        expect_state(0, 32'h80,  1'b1, 1'b0, 32'h80,  3);
        expect_state(1, 32'h108, 1'b1, 1'b0, 32'h102, 4);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
